// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from the 8-deep FIFO and sends each one as a serial frame.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        empty,
  input  logic [7:0]  fifo_data,
  output logic        rd,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          tx_q, tx_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          cyc_last_s;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign cyc_last_s = (cyc_q == CYC_LAST);

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      frame_cnt_q <= 16'd0;
      tx_q        <= 1'b1;
      rd_q        <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_cnt_q <= frame_cnt_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      busy_q      <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Next-state logic; tx_d is the line level for the state being entered
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_cnt_d = frame_cnt_q;
    tx_d        = tx_q;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !empty) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_data;
        cyc_d   = '0;
        bit_d   = 3'd0;
        tx_d    = 1'b0;
        state_d = START;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = ^fifo_data;
`endif
      end
      START: begin
        if (cyc_last_s) begin
          cyc_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      DATA: begin
        if (cyc_last_s) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            // Shift first so the next bit to send is always shift_q[0]
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (cyc_last_s) begin
          cyc_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
`endif
      STOP: begin
        if (cyc_last_s) begin
          cyc_d       = '0;
          tx_d        = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      default: begin
        cyc_d   = '0;
        bit_d   = 3'd0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    rd_d   = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  assign rd        = rd_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds the DUT, a line monitor
// decodes every frame and compares it against bytes queued at stimulus time.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FLEN = NB * CPB;

  logic        clk;
  logic        rst;
  logic        tx_en;
  logic        empty;
  logic [7:0]  fifo_data;
  logic        rd;
  logic        tx;
  logic        busy;
  logic [15:0] frame_cnt;

  int          errors = 0;
  int          checks = 0;
  int          rd_cnt = 0;
  int          cyc = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  push_q[$];
  logic [7:0]  exp_q[$];
  int          start_q[$];
  logic [15:0] exp_cnt = 16'd0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .empty     (empty),
    .fifo_data (fifo_data),
    .rd        (rd),
    .tx        (tx),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input bit ok, input string name, input longint unsigned act,
                       input longint unsigned req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Ideal line waveform of one frame, one entry per clock, from the frame rules
  function automatic logic [63:0] frame_wave(input logic [7:0] b);
    logic [63:0] w;
    logic        lvl;
    w = '0;
    for (int k = 0; k < NB; k++) begin
      if (k == 0)            lvl = 1'b0;
      else if (k <= 8)       lvl = b[k-1];
      else if (k == NB - 1)  lvl = 1'b1;
      else                   lvl = ^b;
      for (int c = 0; c < CPB; c++) w[k*CPB + c] = lvl;
    end
    return w;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    push_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // FIFO model with one-cycle read latency; also polices rd
  initial begin
    logic rd_s;
    logic rd_prev;
    rd_prev = 1'b0;
    empty <= 1'b1;
    fifo_data <= 8'h00;
    forever begin
      @(negedge clk);
      rd_s = rd;
      if (rd_s) begin
        rd_cnt++;
        check(fifo_q.size() != 0, "rd_nonempty", fifo_q.size(), 1);
        check(!rd_prev, "rd_single_cycle", rd_prev, 0);
      end
      rd_prev = rd_s;
      @(posedge clk);
      cyc++;
      if (rd_s && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
      while (push_q.size() != 0 && fifo_q.size() < 8) fifo_q.push_back(push_q.pop_front());
      empty <= (fifo_q.size() == 0);
    end
  end

  // Line monitor: captures each frame and pops the scoreboard
  initial begin
    logic [63:0] got;
    logic [63:0] want;
    logic [7:0]  b;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst && tx == 1'b0) begin
        start_q.push_back(cyc);
        got = '0;
        aborted = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
          if (i != 0) @(negedge clk);
          if (!rst) begin
            aborted = 1'b1;
            break;
          end
          got[i] = tx;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_frame", got, 0);
          end else begin
            b = exp_q.pop_front();
            want = frame_wave(b);
            check(got == want, "frame_wave", got, want);
          end
          exp_cnt = exp_cnt + 16'd1;
          @(negedge clk);
          if (rst) begin
            check(frame_cnt == exp_cnt, "frame_cnt", frame_cnt, exp_cnt);
            check(busy == 1'b0, "busy_after_frame", busy, 0);
          end
        end
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while ((push_q.size() != 0 || fifo_q.size() != 0 || exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(n < 3000, "drain_timeout", n, 3000);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl);
    int n;
    n = 0;
    while (busy != lvl && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(busy == lvl, "busy_wait_timeout", busy, lvl);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r0;
    rst = 1'b1;
    tx_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    check(tx == 1'b1, "reset_tx", tx, 1);
    check(rd == 1'b0, "reset_rd", rd, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(frame_cnt == 16'd0, "reset_frame_cnt", frame_cnt, 0);

    // Single byte held in FIFO across reset release
    tx_en = 1'b1;
    push_byte(8'hA5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_drain();
    repeat (10) @(negedge clk);
    check(rd_cnt == 1, "s1_rd_pulses", rd_cnt, 1);
    check(frame_cnt == 16'd1, "s1_frame_cnt", frame_cnt, 1);

    // Parity pair (plain build checks same bytes without parity)
    push_byte(8'hA5);
    push_byte(8'h07);
    wait_drain();
    check(frame_cnt == 16'd3, "s2_frame_cnt", frame_cnt, 3);

    // Back-to-back frames
    start_q.delete();
    r0 = rd_cnt;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    wait_drain();
    check(rd_cnt - r0 == 3, "s3_rd_pulses", rd_cnt - r0, 3);
    check(start_q.size() == 3, "s3_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check(start_q[1] - start_q[0] == FLEN + 3, "s3_gap1", start_q[1] - start_q[0], FLEN + 3);
      check(start_q[2] - start_q[1] == FLEN + 3, "s3_gap2", start_q[2] - start_q[1], FLEN + 3);
    end
    check(frame_cnt == 16'd6, "s3_frame_cnt", frame_cnt, 6);

    // tx_en dropped mid-frame
    r0 = rd_cnt;
    push_byte(8'h3C);
    push_byte(8'hC3);
    wait_busy(1'b1);
    repeat (12) @(negedge clk);
    tx_en = 1'b0;
    wait_busy(1'b0);
    repeat (10) @(negedge clk);
    check(rd_cnt - r0 == 1, "s4_one_rd", rd_cnt - r0, 1);
    check(busy == 1'b0, "s4_idle", busy, 0);
    check(fifo_q.size() == 1, "s4_byte_left", fifo_q.size(), 1);
    tx_en = 1'b1;
    wait_drain();
    check(rd_cnt - r0 == 2, "s4_second_rd", rd_cnt - r0, 2);
    check(frame_cnt == 16'd8, "s4_frame_cnt", frame_cnt, 8);

    // Reset in the middle of DATA
    r0 = rd_cnt;
    push_byte(8'h5A);
    wait_busy(1'b1);
    repeat (12) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check(tx == 1'b1, "s5_tx", tx, 1);
    check(rd == 1'b0, "s5_rd", rd, 0);
    check(busy == 1'b0, "s5_busy", busy, 0);
    check(frame_cnt == 16'd0, "s5_frame_cnt", frame_cnt, 0);
    void'(exp_q.pop_front());
    exp_cnt = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check(busy == 1'b0, "s5_stay_idle", busy, 0);
    check(tx == 1'b1, "s5_line_high", tx, 1);
    check(rd_cnt - r0 == 1, "s5_no_new_rd", rd_cnt - r0, 1);

    // Counter wrap from a forced 0xFFFF
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    #1;
    check(frame_cnt == 16'hFFFF, "s6_preload", frame_cnt, 16'hFFFF);
    push_byte(8'h81);
    wait_drain();
    check(frame_cnt == 16'h0000, "s6_wrap", frame_cnt, 0);

    // Randomized bursts with tx_en toggling
    for (int it = 0; it < 15; it++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) push_byte(8'($urandom_range(0, 255)));
      tx_en = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(5, 60)) @(negedge clk);
    end
    tx_en = 1'b1;
    wait_drain();
    check(exp_q.size() == 0, "rand_all_sent", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
